// File: rtl/m_axis_cq_adapt_x8.sv
// Completer Request (CQ) adapter for the x8 256-bit UltraScale PCIe core.
// Rewrites the 128-bit CQ descriptor into a legacy 3DW/4DW request TLP header.
module m_axis_cq_adapt_x8 #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 32
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  input  logic [DATA_WIDTH-1:0] m_axis_cq_tdata,
  input  logic [KEEP_WIDTH-1:0] m_axis_cq_tkeep,
  input  logic                  m_axis_cq_tlast,
  input  logic [84:0]           m_axis_cq_tuser,
  input  logic                  m_axis_cq_tvalid,
  output logic                  m_axis_cq_tready,
  output logic [DATA_WIDTH-1:0] m_axis_cq_tdata_a,
  output logic [KEEP_WIDTH-1:0] m_axis_cq_tkeep_a,
  output logic                  m_axis_cq_tlast_a,
  output logic [10:0]           m_axis_cq_tuser_a,
  output logic                  m_axis_cq_tvalid_a,
  input  logic                  m_axis_cq_tready_a,
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PASS  = 3'd1,
    S_HOLD  = 3'd2,
    S_FLUSH = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [223:0]  hold, hold_d;
  logic [6:0]    hold_keep, hold_keep_d;
  logic          drop_after, drop_after_d;
  logic [10:0]   pkt_user, pkt_user_d;

  logic          load;
  logic [255:0]  ld_data;
  logic [7:0]    ld_keep;
  logic          ld_last;

  // Handshake: a beat transfers on a clock edge where valid && ready are both 1.
  // Valid never drops and data never changes while valid is 1 and ready is 0.
  logic can_load, accept;
  assign can_load         = !m_axis_cq_tvalid_a || m_axis_cq_tready_a;
  assign m_axis_cq_tready = can_load && (state != S_FLUSH);
  assign accept           = m_axis_cq_tvalid && m_axis_cq_tready;
  assign fsm_state        = state;

  logic       sop, disc;
  logic [3:0] first_be, last_be, reqtype;
  logic       addr_is_64;
  assign sop        = m_axis_cq_tuser[40];
  assign disc       = m_axis_cq_tuser[41];
  assign first_be   = m_axis_cq_tuser[3:0];
  assign last_be    = m_axis_cq_tuser[7:4];
  assign reqtype    = m_axis_cq_tdata[78:75];
  assign addr_is_64 = |m_axis_cq_tdata[63:32];

  logic unused_tuser;
  assign unused_tuser = ^{m_axis_cq_tuser[84:42], m_axis_cq_tuser[39:8]};

  logic       supported, use_4dw;
  logic [1:0] fmt;
  logic [4:0] tlp_type;
  logic [31:0] hdr_dw0, hdr_dw1, hdr_addr_hi, hdr_addr_lo;

  // IO requests are always 3DW regardless of the upper address bits.
  always_comb begin
    supported = 1'b1;
    use_4dw   = 1'b0;
    fmt       = 2'b00;
    tlp_type  = 5'b00000;
    case (reqtype)
      4'b0000: begin use_4dw = addr_is_64; fmt = {1'b0, addr_is_64}; end
      4'b0001: begin use_4dw = addr_is_64; fmt = {1'b1, addr_is_64}; end
      4'b0010: tlp_type = 5'b00010;
      4'b0011: begin fmt = 2'b10; tlp_type = 5'b00010; end
      default: supported = 1'b0;
    endcase
  end

  assign hdr_dw0     = {1'b0, fmt, tlp_type, 1'b0, m_axis_cq_tdata[123:121], 4'b0000,
                        1'b0, 1'b0, m_axis_cq_tdata[125:124], 2'b00, m_axis_cq_tdata[73:64]};
  assign hdr_dw1     = {m_axis_cq_tdata[95:80], m_axis_cq_tdata[103:96], last_be, first_be};
  assign hdr_addr_hi = m_axis_cq_tdata[63:32];
  assign hdr_addr_lo = {m_axis_cq_tdata[31:2], 2'b00};

  always_comb begin
    state_d      = state;
    hold_d       = hold;
    hold_keep_d  = hold_keep;
    drop_after_d = drop_after;
    pkt_user_d   = pkt_user;
    load         = 1'b0;
    ld_data      = '0;
    ld_keep      = '0;
    ld_last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && sop) begin
          pkt_user_d = {m_axis_cq_tdata[114:112], last_be, first_be};
          if (!supported) begin
            state_d = m_axis_cq_tlast ? S_IDLE : S_DROP;
          end else if (use_4dw) begin
            load    = 1'b1;
            ld_data = {m_axis_cq_tdata[255:128], hdr_addr_lo, hdr_addr_hi, hdr_dw1, hdr_dw0};
            ld_keep = {m_axis_cq_tkeep[7:4], 4'hF};
            ld_last = m_axis_cq_tlast || disc;
            state_d = m_axis_cq_tlast ? S_IDLE : (disc ? S_DROP : S_PASS);
          end else begin
            hold_d       = {m_axis_cq_tdata[255:128], hdr_addr_lo, hdr_dw1, hdr_dw0};
            hold_keep_d  = {m_axis_cq_tkeep[7:4], 3'b111};
            drop_after_d = disc && !m_axis_cq_tlast;
            state_d      = (m_axis_cq_tlast || disc) ? S_FLUSH : S_HOLD;
          end
        end
      end
      S_PASS: begin
        if (accept) begin
          load    = 1'b1;
          ld_data = m_axis_cq_tdata;
          ld_keep = m_axis_cq_tkeep;
          ld_last = m_axis_cq_tlast || disc;
          state_d = m_axis_cq_tlast ? S_IDLE : (disc ? S_DROP : S_PASS);
        end
      end
      S_HOLD: begin
        // Output takes input DW0 on top of the 7 held DWs; the rest is held back.
        if (accept) begin
          load        = 1'b1;
          ld_data     = {m_axis_cq_tdata[31:0], hold};
          ld_keep     = {m_axis_cq_tkeep[0], hold_keep};
          hold_d      = m_axis_cq_tdata[255:32];
          hold_keep_d = m_axis_cq_tkeep[7:1];
          if (m_axis_cq_tlast) begin
            if (m_axis_cq_tkeep[7:1] == 7'd0) begin
              ld_last = 1'b1;
              state_d = S_IDLE;
            end else begin
              drop_after_d = 1'b0;
              state_d      = S_FLUSH;
            end
          end else if (disc) begin
            ld_last = 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_FLUSH: begin
        if (can_load) begin
          load         = 1'b1;
          ld_data      = {32'd0, hold};
          ld_keep      = {1'b0, hold_keep};
          ld_last      = 1'b1;
          drop_after_d = 1'b0;
          state_d      = drop_after ? S_DROP : S_IDLE;
        end
      end
      S_DROP: begin
        if (accept && m_axis_cq_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state              <= S_IDLE;
      hold               <= '0;
      hold_keep          <= '0;
      drop_after         <= 1'b0;
      pkt_user           <= '0;
      m_axis_cq_tvalid_a <= 1'b0;
      m_axis_cq_tdata_a  <= '0;
      m_axis_cq_tkeep_a  <= '0;
      m_axis_cq_tlast_a  <= 1'b0;
      m_axis_cq_tuser_a  <= '0;
    end else begin
      state      <= state_d;
      hold       <= hold_d;
      hold_keep  <= hold_keep_d;
      drop_after <= drop_after_d;
      pkt_user   <= pkt_user_d;
      if (load) begin
        m_axis_cq_tvalid_a <= 1'b1;
        m_axis_cq_tdata_a  <= ld_data;
        m_axis_cq_tkeep_a  <= ld_keep;
        m_axis_cq_tlast_a  <= ld_last;
        m_axis_cq_tuser_a  <= pkt_user_d;
      end else if (m_axis_cq_tready_a) begin
        m_axis_cq_tvalid_a <= 1'b0;
      end
    end
  end

endmodule

// File: doc/m_axis_cq_adapt_x8.md
Name: m_axis_cq_adapt_x8

Overview:
- Receive-side adapter for the x8 256-bit UltraScale PCIe hard IP, in the path that feeds the completer's requests.
- Converts Completer Request (CQ) AXI-Stream beats, which carry a 128-bit CQ descriptor, into legacy-format request TLPs (3DW or 4DW header) on the user-side stream. Completer logic consumes this stream and later returns completions via the CC path.
- Handles header rewrite, 1-DW payload realignment for 3DW headers, backpressure, and dropping of unsupported requests.

Parameters:
- DATA_WIDTH, 256, stream data width; only 256 is supported.
- KEEP_WIDTH, DATA_WIDTH/32, number of DWORD-enable bits.

Ports:
- user_clk  in  1  clock.
- user_reset_n  in  1  asynchronous active-low reset.
- m_axis_cq_tdata  in  256  CQ data from hard IP.
- m_axis_cq_tkeep  in  8  DW enables.
- m_axis_cq_tlast  in  1  end of packet.
- m_axis_cq_tuser  in  85  CQ sideband. Fields used: [3:0] first_be, [7:4] last_be, [40] sop, [41] discontinue.
- m_axis_cq_tvalid  in  1  valid.
- m_axis_cq_tready  out  1  ready to hard IP.
- m_axis_cq_tdata_a  out  256  legacy TLP data.
- m_axis_cq_tkeep_a  out  8  DW enables, contiguous from DW0.
- m_axis_cq_tlast_a  out  1  end of TLP.
- m_axis_cq_tuser_a  out  11  {bar_id[2:0], last_be[3:0], first_be[3:0]}; valid on the first beat.
- m_axis_cq_tvalid_a  out  1  valid.
- m_axis_cq_tready_a  in  1  ready from user logic.

Behaviour:
- Reset (async assert, sync release): tvalid_a=0, tlast_a=0, tkeep_a=0, tdata_a=0, tuser_a=0, FSM=IDLE, hold register cleared. tready may be 1 in reset.
- Output register stage: m_axis_cq_tready = !out_valid | m_axis_cq_tready_a, gated by FSM; it stays 0 during the FLUSH cycle. Output holds stable while tvalid_a=1 and tready_a=0.
- Descriptor decode (first beat):
  - addr = tdata[63:2]
  - dwcnt = tdata[74:64]; length = dwcnt[9:0], where 1024 encodes as 0.
  - reqtype = tdata[78:75]
  - reqid = tdata[95:80]
  - tag = tdata[103:96]
  - bar_id = tdata[114:112]
  - tc = tdata[123:121]
  - attr = tdata[125:124]
- Header format:
  - 4DW when addr[63:32] != 0, otherwise 3DW.
  - Type mapping:
    - 0000 MRd: fmt 00 (3DW) or 01 (4DW), type 00000.
    - 0001 MWr: fmt 10 or 11, type 00000.
    - 0010 IORd: fmt 00, type 00010.
    - 0011 IOWr: fmt 10, type 00010.
  - Any other reqtype goes to DROP.
- Header DWs:
  - DW0 = {1'b0, fmt, type, 1'b0, tc, 4'b0, TD=0, EP=0, attr, 2'b0, length}.
  - DW1 = {reqid, tag, last_be, first_be}.
  - 3DW: DW2 = {addr[31:2], 2'b00}.
  - 4DW: DW2 = addr[63:32], DW3 = {addr[31:2], 2'b00}.
- FSM states: IDLE, PASS, HOLD, FLUSH, DROP.
- IDLE:
  - Accepts a beat with sop=1. A beat with sop=0 is consumed and discarded.
  - 4DW goes to PASS. 3DW goes to HOLD. Unsupported type goes to DROP.
  - If the first beat also has tlast: a 4DW packet emits immediately and returns to IDLE; a 3DW packet goes to FLUSH.
- PASS (4DW): no shift.
  - First output beat = header DW0..3 + input DW4..7.
  - Later beats pass through unchanged; tkeep_a = tkeep.
  - Latency 1 cycle. Returns to IDLE on tlast.
- HOLD (3DW): payload shifts down by one DW.
  - The hold register keeps 7 DWs: header DW0..2 + input DW4..7 on the first beat, or input DW1..7 on later beats.
  - On the next input beat: emit {in.DW0, hold}. The hold register reloads with in.DW1..7.
  - If that input beat is tlast with tkeep==8'h01, the emitted beat is last and the FSM goes to IDLE (no flush).
  - If that input beat is tlast with more than one DW, go to FLUSH.
- FLUSH: emit the remaining hold DWs with tlast_a=1, then return to IDLE. m_axis_cq_tready=0 in this cycle.
- DROP: consume beats with tready=1 and no output, until tlast, then IDLE.
- Discontinue=1 on any accepted beat: emit the current/next output beat with tlast_a=1, then enter DROP; go to IDLE instead if that beat had tlast.
- Reset mid-packet: all state is lost; the next beat must have sop=1.

Test Plan:
- 3DW MRd, addr 0x1000_0040, len 1, tag 0x12, reqid 0x0100, first_be F, single input beat with tlast -> one output beat:
  - DW0=0x00000001, DW1=0x0100120F, DW2=0x10000040
  - tkeep_a=0x07, tlast_a=1, tuser_a first_be=F.
- 3DW MWr, len 5: beat0 carries descriptor + 4 payload DWs (tkeep 0xFF); beat1 carries 1 DW (tkeep 0x01, tlast) -> single output beat:
  - DW0=0x40000005, DW3..7 = payload0..4
  - tkeep_a=0xFF, tlast_a=1; no FLUSH cycle.
- 3DW MWr, len 16 -> three output beats:
  - tkeep_a 0xFF, 0xFF, 0x07; last beat carries payload13..15 in DW0..2
  - FLUSH asserted once, with tready=0 for that cycle.
- 4DW MWr, addr 0x1_0000_0000, len 4 -> one beat:
  - DW0=0x60000004, DW2=0x00000001, DW3=0x00000000, DW4..7 = payload
  - latency 1 cycle.
- reqtype 0x8 packet of 3 beats followed by a 3DW MRd -> nothing is emitted for the first packet; the MRd is emitted normally.
- tready_a held low for 5 cycles mid-packet, then random toggling -> no data loss or duplication, output stable while stalled.
- Separately, async reset asserted mid-HOLD -> tvalid_a=0 immediately.
